// File: rtl/counter_slot_arbiter.sv
// Round-robin scheduler sharing one internal WIDTH-bit up counter among NREQ requesters.
// Optional macro SLOT_ABORT_EN: the owner dropping req during RUN aborts its slot without a done pulse.

module slot_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;
endmodule

module counter_slot_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  input  logic                    pause,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    cnt_en,
  output logic [WIDTH-1:0]        q,
  output logic [NREQ-1:0]         done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [WIDTH-1:0]  target_reg, target_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [WIDTH-1:0]  len_arr [NREQ];
  logic              found;
  logic [PW-1:0]     winner;
  int                arb_idx;
  logic              cnt_clr, cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = len[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(ptr_reg) + k) % NREQ;
      if (!found && req[arb_idx]) begin
        found  = 1'b1;
        winner = arb_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    target_next = target_reg;
    ptr_next    = ptr_reg;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next       = RUN;
          gnt_next         = '0;
          gnt_next[winner] = 1'b1;
          target_next      = len_arr[winner];
          ptr_next         = (winner == LAST) ? '0 : winner + 1'b1;
          cnt_clr          = 1'b1;
        end
      end
      RUN: begin
`ifdef SLOT_ABORT_EN
        if ((req & gnt_reg) == '0) begin
          state_next = IDLE;
          gnt_next   = '0;
          cnt_clr    = 1'b1;
        end else
`endif
        if (q == target_reg) begin
          // Completion does not wait for pause to drop.
          state_next = DONE;
        end else begin
          cnt_inc = ~pause;
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_clr    = 1'b1;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      target_reg <= '0;
      ptr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      target_reg <= target_next;
      ptr_reg    <= ptr_next;
    end
  end

  slot_up_counter #(.WIDTH(WIDTH)) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_inc),
    .q   (q)
  );

  assign gnt    = gnt_reg;
  assign busy   = (state_reg != IDLE);
  assign cnt_en = (state_reg == RUN) && !pause;
  assign done   = (state_reg == DONE) ? gnt_reg : '0;
endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed self-checking bench for counter_slot_arbiter (WIDTH=4, NREQ=4).
// Abort expectations follow SLOT_ABORT_EN when the same macro is defined for the bench.

module tb_counter_slot_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic        pause;
  logic [3:0]  gnt;
  logic        busy;
  logic        cnt_en;
  logic [3:0]  q;
  logic [3:0]  done;

  int checks;
  int errors;

  counter_slot_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .len    (len),
    .pause  (pause),
    .gnt    (gnt),
    .busy   (busy),
    .cnt_en (cnt_en),
    .q      (q),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Runs the current slot to its done pulse (bounded), then releases all requests.
  task automatic finish_slot(input string name);
    int n;
    n = 0;
    while (done == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (done == 4'b0) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required nonzero", name, done, n);
    end
    req = 4'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0; len = 16'h0; pause = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, busy, cnt_en, q, done} !== 14'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b busy=%b cnt_en=%b q=%0d done=%b required all 0",
               gnt, busy, cnt_en, q, done);
    end
    $display("test_reset: gnt=%b busy=%b q=%0d", gnt, busy, q);
  endtask

  task automatic test_single();
    rst = 1'b1;
    req = 4'b0001;
    len = 16'h0005;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || q !== 4'd0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b busy=%b q=%0d required 0001/1/0", gnt, busy, q);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (q !== 4'(i) || done !== 4'b0 || cnt_en !== 1'b1) begin
        errors++;
        $display("FAIL single_count: q=%0d done=%b cnt_en=%b required %0d/0000/1", q, done, cnt_en, i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0001 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_done: done=%b gnt=%b required 0001/0001", done, gnt);
    end
    req = 4'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0 || q !== 4'd0 || done !== 4'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b gnt=%b q=%0d done=%b required all 0", busy, gnt, q, done);
    end
    $display("test_single: slot of 5 complete, busy=%b", busy);
  endtask

  task automatic test_contention();
    logic [3:0] expv;
    do_reset();
    req = 4'b1111;
    len = 16'h2222;
    for (int r = 0; r < 4; r++) begin
      expv = 4'b0001 << r;
      tick();
      checks++;
      if (gnt !== expv) begin
        errors++;
        $display("FAIL contention_grant: gnt=%b required %b", gnt, expv);
      end
      tick();
      tick();
      tick();
      checks++;
      if (done !== expv || q !== 4'd2) begin
        errors++;
        $display("FAIL contention_done: done=%b q=%0d required %b/2", done, q, expv);
      end
      req[r] = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL contention_idle: busy=%b required 0", busy);
      end
      $display("test_contention: slot %0d granted gnt=%b", r, expv);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL contention_wrap: gnt=%b required 0001", gnt);
    end
    finish_slot("contention");
  endtask

  task automatic test_pause();
    do_reset();
    req = 4'b0001;
    len = 16'h0004;
    tick();
    tick();
    tick();
    pause = 1'b1;
    #1;
    checks++;
    if (q !== 4'd2 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: q=%0d cnt_en=%b required 2/0", q, cnt_en);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'd2 || cnt_en !== 1'b0 || done !== 4'b0) begin
        errors++;
        $display("FAIL pause_hold: q=%0d cnt_en=%b done=%b required 2/0/0000", q, cnt_en, done);
      end
    end
    pause = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd4 || done !== 4'b0) begin
      errors++;
      $display("FAIL pause_resume: q=%0d done=%b required 4/0000", q, done);
    end
    tick();
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL pause_done: done=%b required 0001", done);
    end
    req = 4'b0;
    tick();
    $display("test_pause: done delayed by 3 cycles");
  endtask

  task automatic test_boundaries();
    do_reset();
    req = 4'b0001;
    len = 16'h0000;
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 4'd0 || done !== 4'b0) begin
      errors++;
      $display("FAIL len0_grant: gnt=%b q=%0d done=%b required 0001/0/0000", gnt, q, done);
    end
    tick();
    checks++;
    if (done !== 4'b0001 || q !== 4'd0) begin
      errors++;
      $display("FAIL len0_done: done=%b q=%0d required 0001/0", done, q);
    end
    req = 4'b0;
    tick();
    req = 4'b0010;
    len = 16'h00F0;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL len15_grant: gnt=%b required 0010", gnt);
    end
    len = 16'h0030;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (q !== 4'(i) || done !== 4'b0) begin
        errors++;
        $display("FAIL len15_count: q=%0d done=%b required %0d/0000", q, done, i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0010 || q !== 4'd15) begin
      errors++;
      $display("FAIL len15_done: done=%b q=%0d required 0010/15", done, q);
    end
    req = 4'b0;
    tick();
    checks++;
    if (q !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len15_idle: q=%0d busy=%b required 0/0", q, busy);
    end
    $display("test_boundaries: len=0 and len=15 slots complete");
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    len = 16'h0005;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (q !== 4'd3) begin
      errors++;
      $display("FAIL midreset_pre: q=%0d required 3", q);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL midreset_async: q=%0d gnt=%b busy=%b done=%b required all 0", q, gnt, busy, done);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (done !== 4'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL midreset_held: done=%b gnt=%b required 0000/0000", done, gnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_rearb: gnt=%b required 0001", gnt);
    end
    finish_slot("midreset");
    $display("test_reset_mid: async clear and pointer reset");
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0001;
    len = 16'h0005;
    tick();
    tick();
    tick();
    req = 4'b0;
    tick();
`ifdef SLOT_ABORT_EN
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0 || q !== 4'd0 || done !== 4'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b gnt=%b q=%0d done=%b cnt_en=%b required all 0",
               busy, gnt, q, done, cnt_en);
    end
    tick();
    checks++;
    if (done !== 4'b0) begin
      errors++;
      $display("FAIL abort_nodone: done=%b required 0000", done);
    end
    $display("test_abort: slot aborted");
`else
    checks++;
    if (q !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL noabort_run: q=%0d busy=%b required 3/1", q, busy);
    end
    tick();
    tick();
    tick();
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL noabort_done: done=%b required 0001", done);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL noabort_idle: busy=%b required 0", busy);
    end
    $display("test_abort: slot ran to completion");
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_pause();
    test_boundaries();
    test_reset_mid();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_slot_arbiter.md
Name: counter_slot_arbiter

Overview:
Round-robin scheduler that shares one WIDTH-bit up counter among NREQ requesters.
- Each requester asks for a timed slot of len[i] counting cycles.
- The block grants one requester, loads and enables the counter, and pulses done to the owner when the count reaches its length.
- Sits between the up-counter datapath and the blocks needing timed intervals; the counter is instantiated internally.

Parameters:
WIDTH, 4, counter and length width in bits
NREQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  NREQ  slot request per requester; level, held until done
len  input  NREQ*WIDTH  requested length; slice i is len[i*WIDTH +: WIDTH], sampled only at grant
pause  input  1  freezes counting during a slot
gnt  output  NREQ  one-hot grant, all zero when idle
busy  output  1  high while any slot is owned (ARB..DONE)
cnt_en  output  1  counter enable, equals RUN & ~pause
q  output  WIDTH  live counter value
done  output  NREQ  one-cycle completion pulse to the owner

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; gnt=0, done=0, busy=0, cnt_en=0, q=0; target=0; RR pointer=0, which makes requester 0 highest priority.
- State IDLE:
  - If req!=0 at an edge: grant the first set bit searching from ptr, ptr+1, ... mod NREQ.
  - At that same edge: gnt=one-hot(winner), target=len[winner], q=0, ptr=winner+1 mod NREQ, state=RUN.
  - If req==0: stay IDLE.
- State RUN:
  - cnt_en = ~pause.
  - Each edge with cnt_en=1 and q!=target: q=q+1.
  - Edge with q==target: state=DONE and done[winner]=1. The done pulse occurs regardless of pause.
  - pause=1 holds q indefinitely.
- State DONE:
  - done high for exactly this cycle; gnt still asserted.
  - Next edge: gnt=0, done=0, q=0, state=IDLE.
- Latency, req rising before edge E0 with len=L and no pause:
  - gnt high after E0.
  - q=1..L after E1..EL.
  - done high after E(L+1).
  - Idle after E(L+2).
  - Slot occupancy is L+3 cycles.
- len=0: q stays 0; done after E1.
- len=2^WIDTH-1: q reaches max; q never wraps because the slot always terminates at target.
- len changes after grant are ignored (target is latched).
- A requester must drop req while done is high or on the cycle after. If req is still high in IDLE, it is re-arbitrated as a new request, now at lowest priority.
- Simultaneous requests: exactly one grant; fairness is guaranteed by pointer rotation, so no requester waits more than NREQ-1 slots.
- New requests arriving during ARB/RUN/DONE wait; they are never preempted.
- Reset asserted mid-slot: immediate return to reset values; no done pulse.

Optional Feature:
SLOT_ABORT_EN
- Defined: if the owner's req drops during RUN, the next edge forces gnt=0, q=0, cnt_en=0, state=IDLE, with no done pulse; ptr is unchanged from its grant-time update.
- Undefined: req is ignored during RUN and the slot always runs to completion with a done pulse.

Test Plan:
1. Reset then single request: rst low 2 cycles, then req=0001, len0=5 -> gnt=0001 after 1 edge; q counts 1..5; done=0001 for one cycle 6 edges after grant; busy low 8 cycles after req.
2. Contention: req=1111, all len=2, each requester drops req on its done -> grant order 0,1,2,3; each slot takes 5 cycles; ptr wraps back to 0.
3. Pause: len=4, pause high for 3 cycles while q=2 -> q holds 2 and cnt_en=0 during the pause; done is delayed exactly 3 cycles.
4. Boundaries: len=0 -> done 1 edge after grant, q stays 0. len=15 -> q reaches 15, done follows, no wrap to 0.
5. Reset mid-slot: drop rst at q=3 -> q, gnt, busy and done go 0 immediately, without waiting for a clock edge; no done pulse; after release, requester 0 wins if req=1111.
6. SLOT_ABORT_EN: drop req at q=2 -> IDLE next edge with no done pulse. Same stimulus without the macro -> slot completes and done fires.
